adc_frontend_emu: RTL and testbench
===================================

# adc_frontend_emu

Synthesizable responder that emulates the board's SPI analog front end, the LTC6912 programmable preamp and the LTC1407A dual 14-bit ADC. It sits on the far side of the capture controller's pins (`SPI_SCK`, `SPI_MOSI`, `AMP_CS`, `AD_CONV` in; `AMP_DOUT`, `AD_DOUT` out). It lets the scope's acquisition path be exercised in simulation and in on-chip loopback without the physical parts. It latches gain words written by the controller, echoes the previous gain, and serves programmable sample pairs in the ADC's 34-clock frame format.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on every SPI input (minimum 2).

Ports:
- `clk` in 1: system clock; all logic runs on it; SPI pins are oversampled.
- `rst` in 1: synchronous, active-high reset.
- `SPI_SCK` in 1: serial clock from the controller; asynchronous to `clk`.
- `SPI_MOSI` in 1: preamp gain data.
- `AMP_CS` in 1: preamp chip select, active low.
- `AD_CONV` in 1: conversion strobe; rising edge starts a frame.
- `sample_a` in 14: channel A code (two's complement) returned in the next frame.
- `sample_b` in 14: channel B code returned in the next frame.
- `AMP_DOUT` out 1: preamp echo of the previously latched gain word.
- `AD_DOUT` out 1: ADC serial data.
- `gain` out 8: last valid gain word, `{gain_b[3:0], gain_a[3:0]}` as transmitted.
- `gain_valid` out 1: one-cycle pulse when `gain` updates.
- `gain_err` out 1: one-cycle pulse when a CS window ends with a bit count other than 8.
- `frame_busy` out 1: high while an ADC frame is in progress.
- `frame_done` out 1: one-cycle pulse after the 34th SCK falling edge of a frame.

## Operation
- Input conditioning:
  - Each SPI input passes through a `SYNC_STAGES` flop chain.
  - Edge detect compares the last two synchronized values, giving `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise`, and `conv_rise`.
- Preamp path, active while synchronized `AMP_CS` is 0:
  - `cs_fall`: clear the bit counter; load the echo register with the current `gain`; drive `AMP_DOUT` = `gain[7]`.
  - `sck_rise`: shift `SPI_MOSI` into `shift[7:0]`, MSB first; increment the bit counter, saturating at 9.
  - `sck_fall`: rotate the echo register left; `AMP_DOUT` = new echo MSB.
  - `cs_rise`:
    - Count == 8: `gain` <= `shift`, pulse `gain_valid`.
    - Otherwise: pulse `gain_err`; `gain` is unchanged.
  - While CS is high, SCK edges are ignored and `AMP_DOUT` holds 0.
- ADC path FSM, states IDLE and FRAME:
  - IDLE --`conv_rise`--> FRAME: latch the frame word `{2'b00, sample_a, 2'b00, sample_b, 2'b00}` (34 bits); bit index = 0; `AD_DOUT` = 0.
  - FRAME, on each `sck_fall`: drive `AD_DOUT` = frame bit[33 - index], then index++.
  - After the `sck_fall` with index 33: pulse `frame_done`, go to IDLE, and `AD_DOUT` returns to 0.
  - `conv_rise` during FRAME restarts the frame: re-latch samples, index = 0; no `frame_done` for the aborted frame.
  - SCK edges in IDLE are ignored; `AD_DOUT` stays 0.
- The preamp and ADC paths are independent; simultaneous `cs_rise` and `conv_rise` are both honoured in the same cycle.
- Reset values: `AMP_DOUT` 0, `AD_DOUT` 0, `gain` 8'h00, `gain_valid` 0, `gain_err` 0, `frame_busy` 0, `frame_done` 0, FSM IDLE, and all synchronizers 0.
- Reset mid-transfer aborts both paths; the first post-reset frame requires a fresh `conv_rise`.

## Timing
- Pin-to-detect latency is `SYNC_STAGES` + 1 `clk` cycles. Outputs (`AMP_DOUT`, `AD_DOUT`, and the pulses) register one cycle after the detect.
- `AD_DOUT` and `AMP_DOUT` are therefore valid `SYNC_STAGES` + 2 cycles after the pin SCK falling edge. The controller samples on SCK high, so each SCK phase must last at least `SYNC_STAGES` + 3 `clk` cycles.
- `gain_valid` and `gain_err` fire `SYNC_STAGES` + 2 cycles after the `AMP_CS` pin rises.
- `frame_busy` rises the cycle after `conv_rise` is detected and falls together with the `frame_done` pulse.
- Data is MSB first on both paths.

## Structure
- Package `adc_emu_pkg` holds:
  - `AMP_BITS` = 8, `ADC_BITS` = 14, `FRAME_BITS` = 34, `GAP_BITS` = 2.
  - FSM state encoding.
  - The frame-assembly function.
- Sub-module `spi_pin_sync` (parameter `SYNC_STAGES`): synchronizer plus rise/fall detect, one instance per input pin.
- The top level holds the preamp shift/echo logic and the ADC frame FSM.

## Test plan
- Reset, then a CS window with MOSI 8'h11 -> `gain` = 8'h11, one `gain_valid` pulse, `AMP_DOUT` echoes 8'h00.
- Second write of 8'hA5 -> `AMP_DOUT` echoes 8'h11; `gain` = 8'hA5 afterwards.
- CS window with 7 SCKs of 8'hFF -> `gain_err` pulse; `gain` stays 8'hA5.
- `sample_a` = 14'h1ABC, `sample_b` = 14'h2001, `AD_CONV` pulse, then 34 SCKs:
  - Bits captured on SCK high = 00, 1ABC MSB-first, 00, 2001 MSB-first, 00.
  - One `frame_done` pulse.
  - A 35th SCK reads 0.
- `AD_CONV` re-pulsed after 10 SCKs with `sample_a` changed to 14'h0005 -> the frame restarts at bit 0 with 14'h0005; exactly one `frame_done` occurs.
- `rst` asserted at SCK 20 of a frame -> all outputs return to reset values; SCKs without `AD_CONV` keep `AD_DOUT` 0.

Source files
------------

// File: rtl/adc_emu_pkg.sv
// adc_emu_pkg: shared widths, ADC FSM encoding and frame assembly for the analog front-end emulator
package adc_emu_pkg;
    localparam int AMP_BITS   = 8;
    localparam int ADC_BITS   = 14;
    localparam int FRAME_BITS = 34;
    localparam int GAP_BITS   = 2;

    typedef enum logic {ST_IDLE, ST_FRAME} adc_state_t;

    // The ADC frame is {gap, A, gap, B, gap}; the gaps read as zeros.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [ADC_BITS-1:0] a, input logic [ADC_BITS-1:0] b);
        return {{GAP_BITS{1'b0}}, a, {GAP_BITS{1'b0}}, b, {GAP_BITS{1'b0}}};
    endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronizer chain plus edge detect for one asynchronous SPI pin
//   clk, rst : system clock, synchronous active-high reset
//   i_pin    : raw asynchronous pin
//   o_level  : synchronized level
//   o_rise   : one-cycle strobe on a synchronized 0->1 transition
//   o_fall   : one-cycle strobe on a synchronized 1->0 transition
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/adc_frontend_emu.sv
// adc_frontend_emu: SPI responder emulating the LTC6912 preamp and LTC1407A dual ADC
//   clk, rst             : system clock, synchronous active-high reset
//   SPI_SCK, SPI_MOSI    : serial clock and preamp gain data from the controller
//   AMP_CS               : preamp chip select, active low
//   AD_CONV              : conversion strobe, rising edge starts an ADC frame
//   sample_a, sample_b   : channel codes served in the next frame
//   AMP_DOUT             : echo of the previously latched gain word
//   AD_DOUT              : ADC serial data
//   gain, gain_valid     : last valid gain word and its update pulse
//   gain_err             : pulse when a CS window ends with a bit count other than 8
//   frame_busy           : ADC frame in progress
//   frame_done           : pulse after the last SCK falling edge of a frame
module adc_frontend_emu
    import adc_emu_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SPI_SCK,
    input  logic                SPI_MOSI,
    input  logic                AMP_CS,
    input  logic                AD_CONV,
    input  logic [ADC_BITS-1:0] sample_a,
    input  logic [ADC_BITS-1:0] sample_b,
    output logic                AMP_DOUT,
    output logic                AD_DOUT,
    output logic [AMP_BITS-1:0] gain,
    output logic                gain_valid,
    output logic                gain_err,
    output logic                frame_busy,
    output logic                frame_done
);
    logic w_sck, w_sck_rise, w_sck_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_cs, w_cs_rise, w_cs_fall;
    logic w_conv, w_conv_rise, w_conv_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck  (.clk(clk), .rst(rst), .i_pin(SPI_SCK),  .o_level(w_sck),  .o_rise(w_sck_rise),  .o_fall(w_sck_fall));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (.clk(clk), .rst(rst), .i_pin(SPI_MOSI), .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs   (.clk(clk), .rst(rst), .i_pin(AMP_CS),   .o_level(w_cs),   .o_rise(w_cs_rise),   .o_fall(w_cs_fall));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_conv (.clk(clk), .rst(rst), .i_pin(AD_CONV),  .o_level(w_conv), .o_rise(w_conv_rise), .o_fall(w_conv_fall));

    // Edge/level outputs of the shared synchronizer that neither path needs.
    logic w_unused;
    assign w_unused = ^{w_sck, w_mosi_rise, w_mosi_fall, w_conv, w_conv_fall};

    // Preamp: shift in on SCK rise, rotate echo out on SCK fall, commit on CS rise.
    logic [AMP_BITS-1:0] r_shift, r_echo, r_gain;
    logic [3:0]          r_cnt;
    logic                r_amp_dout, r_gain_valid, r_gain_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_echo       <= '0;
            r_gain       <= '0;
            r_cnt        <= '0;
            r_amp_dout   <= 1'b0;
            r_gain_valid <= 1'b0;
            r_gain_err   <= 1'b0;
        end else begin
            r_gain_valid <= 1'b0;
            r_gain_err   <= 1'b0;
            if (w_cs_fall) begin
                r_cnt      <= '0;
                r_echo     <= r_gain;
                r_amp_dout <= r_gain[AMP_BITS-1];
            end else if (!w_cs) begin
                if (w_sck_rise) begin
                    r_shift <= {r_shift[AMP_BITS-2:0], w_mosi};
                    r_cnt   <= (r_cnt == 4'd9) ? r_cnt : r_cnt + 4'd1;
                end
                if (w_sck_fall) begin
                    r_echo     <= {r_echo[AMP_BITS-2:0], r_echo[AMP_BITS-1]};
                    r_amp_dout <= r_echo[AMP_BITS-2];
                end
            end
            if (w_cs) r_amp_dout <= 1'b0;
            if (w_cs_rise) begin
                if (r_cnt == 4'(AMP_BITS)) begin
                    r_gain       <= r_shift;
                    r_gain_valid <= 1'b1;
                end else begin
                    r_gain_err <= 1'b1;
                end
            end
        end
    end

    // ADC frame FSM
    adc_state_t               r_state, w_next;
    logic [FRAME_BITS-1:0]    r_frame;
    logic [5:0]               r_idx;
    logic                     r_ad_dout, r_frame_done, w_last;

    always_comb begin
        w_last = 1'b0;
        w_next = r_state;
        w_last = (r_state == ST_FRAME) && w_sck_fall && (r_idx == 6'(FRAME_BITS-1)) && !w_conv_rise;
        w_next = w_conv_rise ? ST_FRAME : (w_last ? ST_IDLE : r_state);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame      <= '0;
            r_idx        <= '0;
            r_ad_dout    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_conv_rise) begin
                r_frame   <= make_frame(sample_a, sample_b);
                r_idx     <= '0;
                r_ad_dout <= 1'b0;
            end else if (r_state == ST_FRAME && w_sck_fall) begin
                // The final bit is a gap bit, so dropping to 0 on the last fall loses nothing.
                r_ad_dout <= w_last ? 1'b0 : r_frame[6'(FRAME_BITS-1) - r_idx];
                r_idx     <= r_idx + 6'd1;
            end
        end
    end

    assign AMP_DOUT   = r_amp_dout;
    assign AD_DOUT    = r_ad_dout;
    assign gain       = r_gain;
    assign gain_valid = r_gain_valid;
    assign gain_err   = r_gain_err;
    assign frame_busy = (r_state == ST_FRAME);
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_adc_frontend_emu.sv
// tb_adc_frontend_emu: scoreboard bench for the preamp echo/gain path and the ADC frame path
module tb_adc_frontend_emu;
    localparam int P = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0, mosi = 1'b0, cs = 1'b1, conv = 1'b0;
    logic [13:0] sa = '0, sb = '0;
    logic        amp_dout, ad_dout, gain_valid, gain_err, frame_busy, frame_done;
    logic [7:0]  gain;

    int n_vec = 0, n_err = 0;
    int n_valid = 0, n_gerr = 0, n_done = 0;
    int v0, e0, d0;
    logic q[$];

    adc_frontend_emu #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SPI_SCK(sck), .SPI_MOSI(mosi), .AMP_CS(cs), .AD_CONV(conv),
        .sample_a(sa), .sample_b(sb), .AMP_DOUT(amp_dout), .AD_DOUT(ad_dout), .gain(gain),
        .gain_valid(gain_valid), .gain_err(gain_err), .frame_busy(frame_busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            n_valid += int'(gain_valid);
            n_gerr  += int'(gain_err);
            n_done  += int'(frame_done);
        end
    end

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic obs);
        if (q.size() == 0) chk({tag, "_queue_empty"}, 34'(q.size()), 34'd1);
        else               chk(tag, 34'(obs), 34'(q.pop_front()));
    endtask

    task automatic amp_xfer(input logic [7:0] v, input int nb, input logic [7:0] echo);
        sck = 1'b0;
        cs  = 1'b0;
        cyc(P);
        for (int i = 0; i < nb; i++) begin
            q.push_back(echo[7-i]);
            mosi = v[7-i];
            sck  = 1'b1;
            cyc(P);
            pop_chk("amp_dout", amp_dout);
            sck = 1'b0;
            cyc(P);
        end
        cs = 1'b1;
        cyc(P);
        chk("amp_dout_cs_high", 34'(amp_dout), 34'd0);
    endtask

    task automatic adc_conv(input logic [13:0] a, input logic [13:0] b);
        sck  = 1'b1;
        sa   = a;
        sb   = b;
        conv = 1'b1;
        cyc(P);
        conv = 1'b0;
        cyc(P);
    endtask

    task automatic push_frame(input logic [13:0] a, input logic [13:0] b, input int n);
        logic [33:0] f;
        f = {2'b00, a, 2'b00, b, 2'b00};
        for (int k = 0; k < n; k++) q.push_back(f[33-k]);
    endtask

    task automatic adc_sck();
        sck = 1'b0;
        cyc(P);
        sck = 1'b1;
        cyc(P);
        pop_chk("ad_dout", ad_dout);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_amp_dout"},   34'(amp_dout),   34'd0);
        chk({tag, "_ad_dout"},    34'(ad_dout),    34'd0);
        chk({tag, "_gain"},       34'(gain),       34'h00);
        chk({tag, "_gain_valid"}, 34'(gain_valid), 34'd0);
        chk({tag, "_gain_err"},   34'(gain_err),   34'd0);
        chk({tag, "_frame_busy"}, 34'(frame_busy), 34'd0);
        chk({tag, "_frame_done"}, 34'(frame_done), 34'd0);
    endtask

    initial begin
        cyc(4);
        chk_reset_vals("reset");
        rst = 1'b0;
        cyc(P);

        v0 = n_valid;
        amp_xfer(8'h11, 8, 8'h00);
        chk("gain_11", 34'(gain), 34'h11);
        chk("valid_count_1", 34'(n_valid - v0), 34'd1);

        amp_xfer(8'hA5, 8, 8'h11);
        chk("gain_a5", 34'(gain), 34'hA5);
        chk("valid_count_2", 34'(n_valid - v0), 34'd2);

        e0 = n_gerr;
        amp_xfer(8'hFF, 7, 8'hA5);
        chk("gain_kept", 34'(gain), 34'hA5);
        chk("gain_err_count", 34'(n_gerr - e0), 34'd1);
        chk("valid_count_3", 34'(n_valid - v0), 34'd2);

        d0 = n_done;
        adc_conv(14'h1ABC, 14'h2001);
        chk("busy_after_conv", 34'(frame_busy), 34'd1);
        push_frame(14'h1ABC, 14'h2001, 34);
        for (int i = 0; i < 34; i++) adc_sck();
        chk("frame_done_count", 34'(n_done - d0), 34'd1);
        chk("busy_after_frame", 34'(frame_busy), 34'd0);
        q.push_back(1'b0);
        adc_sck();

        d0 = n_done;
        adc_conv(14'h1ABC, 14'h2001);
        push_frame(14'h1ABC, 14'h2001, 10);
        for (int i = 0; i < 10; i++) adc_sck();
        adc_conv(14'h0005, 14'h2001);
        push_frame(14'h0005, 14'h2001, 34);
        for (int i = 0; i < 34; i++) adc_sck();
        chk("restart_done_count", 34'(n_done - d0), 34'd1);

        d0 = n_done;
        adc_conv(14'h1ABC, 14'h2001);
        push_frame(14'h1ABC, 14'h2001, 20);
        for (int i = 0; i < 20; i++) adc_sck();
        rst = 1'b1;
        cyc(4);
        chk_reset_vals("midreset");
        rst = 1'b0;
        cyc(P);
        chk("post_reset_busy", 34'(frame_busy), 34'd0);
        chk("post_reset_gain", 34'(gain), 34'h00);
        for (int i = 0; i < 6; i++) begin
            q.push_back(1'b0);
            adc_sck();
        end
        chk("reset_done_count", 34'(n_done - d0), 34'd0);
        chk("queue_drained", 34'(q.size()), 34'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
